mcu_io_ctrl: RTL and testbench

Memory-mapped I/O controller between the pipelined CPU core's load/store port and the board peripherals. It buffers CPU grid-pixel writes into a 4-entry FIFO drained to the VGA grid port. It also samples the switches, latches keypad events, and raises an interrupt on a pending key or an emptied FIFO. It replaces direct CPU wiring to the VGA/keypad/switch ports with one handshaked register interface.

---
 rtl/io_ctrl_pkg.sv | 44 ++++
 rtl/grid_wr_fifo.sv | 54 +++++
 rtl/mcu_io_ctrl.sv | 166 ++++++++++++++++
 tb/tb_mcu_io_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/io_ctrl_pkg.sv
// rtl/io_ctrl_pkg.sv - shared constants and types for the MCU I/O controller
// Purpose: register addresses, access FSM state encoding and STATUS bit
//          positions used by mcu_io_ctrl and its testbench.
// Ports:   none (package).
package io_ctrl_pkg;

    localparam logic [7:0] ADDR_POS    = 8'h00;
    localparam logic [7:0] ADDR_COLOR  = 8'h01;
    localparam logic [7:0] ADDR_STATUS = 8'h02;
    localparam logic [7:0] ADDR_SW     = 8'h03;
    localparam logic [7:0] ADDR_KEY    = 8'h04;
    localparam logic [7:0] ADDR_IRQ_EN = 8'h05;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } io_state_t;

    // STATUS layout: {3'b0, overrun, key_valid, fifo_full, fifo_empty, irq}
    localparam int STAT_IRQ       = 0;
    localparam int STAT_EMPTY     = 1;
    localparam int STAT_FULL      = 2;
    localparam int STAT_KEY_VALID = 3;
    localparam int STAT_OVERRUN   = 4;

    function automatic logic [7:0] pack_status(
        input logic overrun,
        input logic key_valid,
        input logic fifo_full,
        input logic fifo_empty,
        input logic irq
    );
        logic [7:0] s;
        s                 = 8'h00;
        s[STAT_OVERRUN]   = overrun;
        s[STAT_KEY_VALID] = key_valid;
        s[STAT_FULL]      = fifo_full;
        s[STAT_EMPTY]     = fifo_empty;
        s[STAT_IRQ]       = irq;
        return s;
    endfunction

endpackage

// File: rtl/grid_wr_fifo.sv
// rtl/grid_wr_fifo.sv - synchronous FIFO buffering grid pixel writes
// Purpose: FIFO_DEPTH x 16-bit FIFO; head is presented combinationally on dout.
// Ports:   clk, rst (async, active-high, flushes contents)
//          push/din  - write side, ignored when full
//          pop/dout  - read side, pop ignored when empty
//          full, empty - occupancy flags derived from pointers with an extra MSB
module grid_wr_fifo #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [15:0] din,
    input  logic        pop,
    output logic [15:0] dout,
    output logic        full,
    output logic        empty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [15:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    // Same index with differing wrap bit means the writer is a full lap ahead.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= 16'h0000;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr              <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/mcu_io_ctrl.sv
// rtl/mcu_io_ctrl.sv - memory-mapped I/O controller for the CPU load/store port
// Purpose: register interface to the VGA grid port (through a write FIFO),
//          the board switches and the keypad, plus a level interrupt.
// Ports:   clk, rst (async, active-high)
//          io_req/io_we/io_addr/io_wdata -> io_rdata/io_ack : CPU access handshake
//          grid_pos/grid_color/grid_wr <- grid_ready        : VGA grid write port
//          sw                                               : synchronized switches
//          key_code/key_strobe                              : keypad events
//          irq                                              : registered interrupt level
module mcu_io_ctrl
    import io_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       io_req,
    input  logic       io_we,
    input  logic [7:0] io_addr,
    input  logic [7:0] io_wdata,
    output logic [7:0] io_rdata,
    output logic       io_ack,
    output logic [7:0] grid_pos,
    output logic [7:0] grid_color,
    output logic       grid_wr,
    input  logic       grid_ready,
    input  logic [7:0] sw,
    input  logic [3:0] key_code,
    input  logic       key_strobe,
    output logic       irq
);

    io_state_t   state;
    logic [7:0]  pos_reg;
    logic [7:0]  color_reg;
    logic [1:0]  irq_en;
    logic [3:0]  key;
    logic        key_valid;
    logic        overrun;

    logic        fifo_full;
    logic        fifo_empty;
    logic [15:0] fifo_dout;
    logic        fifo_push;
    logic        fifo_pop;

    logic        color_wr;
    logic        idle_take;
    logic        key_rd;
    logic [7:0]  rd_mux;

    always_comb begin
        color_wr  = io_we && (io_addr == ADDR_COLOR);
        // Access completes from IDLE unless it is a COLOR write blocked by a full FIFO.
        idle_take = (state == IDLE) && io_req && !(color_wr && fifo_full);
        // Pushes happen on the same edge that moves the FSM into ACK.
        fifo_push = !fifo_full &&
                    (((state == IDLE) && io_req && color_wr) || (state == WAIT));
        key_rd    = idle_take && !io_we && (io_addr == ADDR_KEY);
        fifo_pop  = grid_ready && !fifo_empty;
    end

    always_comb begin
        rd_mux = 8'h00;
        case (io_addr)
            ADDR_POS:    rd_mux = pos_reg;
            ADDR_COLOR:  rd_mux = color_reg;
            ADDR_STATUS: rd_mux = pack_status(overrun, key_valid, fifo_full, fifo_empty, irq);
            ADDR_SW:     rd_mux = sw;
            ADDR_KEY:    rd_mux = {4'b0000, key};
            ADDR_IRQ_EN: rd_mux = {6'b000000, irq_en};
            default:     rd_mux = 8'h00;
        endcase
    end

    // Access FSM; io_ack is registered and coincides with the ACK state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            io_ack    <= 1'b0;
            io_rdata  <= 8'h00;
            pos_reg   <= 8'h00;
            color_reg <= 8'h00;
            irq_en    <= 2'b00;
        end else begin
            io_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (io_req) begin
                        if (color_wr && fifo_full) begin
                            state <= WAIT;
                        end else begin
                            state  <= ACK;
                            io_ack <= 1'b1;
                            if (io_we) begin
                                case (io_addr)
                                    ADDR_POS:    pos_reg   <= io_wdata;
                                    ADDR_COLOR:  color_reg <= io_wdata;
                                    ADDR_IRQ_EN: irq_en    <= io_wdata[1:0];
                                    default:     ;
                                endcase
                            end else begin
                                io_rdata <= rd_mux;
                            end
                        end
                    end
                end
                WAIT: begin
                    if (!fifo_full) begin
                        state     <= ACK;
                        io_ack    <= 1'b1;
                        color_reg <= io_wdata;
                    end
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Keypad latch; a KEY read on the same edge as a strobe keeps the new key valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key       <= 4'h0;
            key_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (key_strobe) begin
            key       <= key_code;
            key_valid <= 1'b1;
            overrun   <= key_rd ? 1'b0 : (overrun | key_valid);
        end else if (key_rd) begin
            key_valid <= 1'b0;
            overrun   <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq <= 1'b0;
        end else begin
            irq <= (irq_en[0] & key_valid) | (irq_en[1] & fifo_empty);
        end
    end

    grid_wr_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (fifo_push),
        .din  ({pos_reg, io_wdata}),
        .pop  (fifo_pop),
        .dout (fifo_dout),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    assign grid_wr    = !fifo_empty;
    assign grid_pos   = fifo_dout[15:8];
    assign grid_color = fifo_dout[7:0];

endmodule

// File: tb/tb_mcu_io_ctrl.sv
// tb/tb_mcu_io_ctrl.sv - self-checking bench for mcu_io_ctrl
module tb_mcu_io_ctrl;
    import io_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       io_req;
    logic       io_we;
    logic [7:0] io_addr;
    logic [7:0] io_wdata;
    logic [7:0] io_rdata;
    logic       io_ack;
    logic [7:0] grid_pos;
    logic [7:0] grid_color;
    logic       grid_wr;
    logic       grid_ready;
    logic [7:0] sw;
    logic [3:0] key_code;
    logic       key_strobe;
    logic       irq;

    int vectors     = 0;
    int miscompares = 0;
    int grid_pops   = 0;

    logic [7:0]  rd_q[$];
    logic [15:0] grid_q[$];

    always #5 clk = ~clk;

    mcu_io_ctrl #(.FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .io_req    (io_req),
        .io_we     (io_we),
        .io_addr   (io_addr),
        .io_wdata  (io_wdata),
        .io_rdata  (io_rdata),
        .io_ack    (io_ack),
        .grid_pos  (grid_pos),
        .grid_color(grid_color),
        .grid_wr   (grid_wr),
        .grid_ready(grid_ready),
        .sw        (sw),
        .key_code  (key_code),
        .key_strobe(key_strobe),
        .irq       (irq)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change at negedge+1; the grid monitor samples at negedge+2.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic access(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                          input logic [7:0] exp, input logic stb = 1'b0,
                          input logic [3:0] code = 4'h0);
        int n;
        io_we    = we;
        io_addr  = addr;
        io_wdata = wdata;
        io_req   = 1'b1;
        if (stb) begin
            key_code   = code;
            key_strobe = 1'b1;
        end
        if (!we) rd_q.push_back(exp);
        n = 0;
        do begin
            step();
            key_strobe = 1'b0;
            n++;
        end while (io_ack !== 1'b1 && n < 20);
        check($sformatf("ack_latency@%02h", addr), 16'(n), 16'd1);
        if (!we && io_ack === 1'b1)
            check($sformatf("rdata@%02h", addr), {8'h00, io_rdata}, {8'h00, rd_q.pop_front()});
        io_req = 1'b0;
        step();
    endtask

    task automatic key_pulse(input logic [3:0] code);
        key_code   = code;
        key_strobe = 1'b1;
        step();
        key_strobe = 1'b0;
    endtask

    // Scoreboard side of the grid port: every accepted beat must match the next expected pixel.
    always begin
        @(negedge clk);
        #2;
        if (grid_wr === 1'b1 && grid_ready === 1'b1) begin
            grid_pops++;
            if (grid_q.size() == 0)
                check("grid_unexpected_beat", {grid_pos, grid_color}, 16'hFFFF ^ {grid_pos, grid_color});
            else
                check("grid_beat", {grid_pos, grid_color}, grid_q.pop_front());
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int   base;
        logic seen;

        rst = 1'b1; io_req = 1'b0; io_we = 1'b0; io_addr = 8'h00; io_wdata = 8'h00;
        grid_ready = 1'b0; sw = 8'h00; key_code = 4'h0; key_strobe = 1'b0;
        repeat (3) step();
        check("rst_io_ack", {15'b0, io_ack}, 16'h0000);
        check("rst_io_rdata", {8'h00, io_rdata}, 16'h0000);
        check("rst_grid_wr", {15'b0, grid_wr}, 16'h0000);
        check("rst_grid_pos", {8'h00, grid_pos}, 16'h0000);
        check("rst_grid_color", {8'h00, grid_color}, 16'h0000);
        check("rst_irq", {15'b0, irq}, 16'h0000);
        rst = 1'b0;
        step();

        access(1'b0, ADDR_STATUS, 8'h00, 8'h02);
        check("idle_irq", {15'b0, irq}, 16'h0000);
        check("idle_grid_wr", {15'b0, grid_wr}, 16'h0000);

        // Single pixel through to the grid port.
        grid_ready = 1'b1;
        access(1'b1, ADDR_POS, 8'h2A, 8'h00);
        grid_q.push_back(16'h2A1C);
        base = grid_pops;
        access(1'b1, ADDR_COLOR, 8'h1C, 8'h00);
        repeat (3) step();
        check("single_beat_count", 16'(grid_pops - base), 16'd1);
        check("single_grid_wr_low", {15'b0, grid_wr}, 16'h0000);
        access(1'b0, ADDR_COLOR, 8'h00, 8'h1C);
        access(1'b0, ADDR_POS, 8'h00, 8'h2A);
        access(1'b0, ADDR_STATUS, 8'h00, 8'h02);

        // Fill the FIFO, stall the fifth write, then release.
        grid_ready = 1'b0;
        access(1'b1, ADDR_POS, 8'h50, 8'h00);
        for (int i = 0; i < 4; i++) begin
            grid_q.push_back({8'h50, 8'hA0 + 8'(i)});
            access(1'b1, ADDR_COLOR, 8'hA0 + 8'(i), 8'h00);
        end
        access(1'b0, ADDR_STATUS, 8'h00, 8'h04);
        grid_q.push_back(16'h50A4);
        io_we = 1'b1; io_addr = ADDR_COLOR; io_wdata = 8'hA4; io_req = 1'b1;
        seen = 1'b0;
        repeat (3) begin
            step();
            if (io_ack === 1'b1) seen = 1'b1;
        end
        check("stall_no_ack", {15'b0, seen}, 16'h0000);
        grid_ready = 1'b1;
        step();
        check("stall_ack_not_yet", {15'b0, io_ack}, 16'h0000);
        step();
        check("stall_ack_after_pop", {15'b0, io_ack}, 16'h0001);
        io_req = 1'b0;
        repeat (8) step();
        check("drain_all_beats", 16'(grid_q.size()), 16'd0);
        check("drain_grid_wr_low", {15'b0, grid_wr}, 16'h0000);
        access(1'b0, ADDR_COLOR, 8'h00, 8'hA4);

        // Keypad overrun and read-clear.
        key_pulse(4'h7);
        key_pulse(4'h3);
        access(1'b0, ADDR_STATUS, 8'h00, 8'h1A);
        access(1'b0, ADDR_KEY, 8'h00, 8'h03);
        access(1'b0, ADDR_STATUS, 8'h00, 8'h02);

        // Strobe on the same edge as a KEY read: old key returned, new key stays valid.
        key_pulse(4'h5);
        access(1'b0, ADDR_KEY, 8'h00, 8'h05, 1'b1, 4'h9);
        access(1'b0, ADDR_STATUS, 8'h00, 8'h0A);
        access(1'b0, ADDR_KEY, 8'h00, 8'h09);
        access(1'b0, ADDR_STATUS, 8'h00, 8'h02);

        // Interrupt from key_valid.
        access(1'b1, ADDR_IRQ_EN, 8'h01, 8'h00);
        access(1'b0, ADDR_IRQ_EN, 8'h00, 8'h01);
        key_pulse(4'h6);
        check("irq_key_lag", {15'b0, irq}, 16'h0000);
        step();
        check("irq_key_set", {15'b0, irq}, 16'h0001);
        access(1'b0, ADDR_STATUS, 8'h00, 8'h0B);
        io_we = 1'b0; io_addr = ADDR_KEY; io_req = 1'b1;
        step();
        check("irq_key_read_ack", {15'b0, io_ack}, 16'h0001);
        check("irq_key_read_data", {8'h00, io_rdata}, 16'h0006);
        check("irq_held_in_ack", {15'b0, irq}, 16'h0001);
        io_req = 1'b0;
        step();
        check("irq_key_cleared", {15'b0, irq}, 16'h0000);

        // Interrupt from an empty FIFO.
        access(1'b1, ADDR_IRQ_EN, 8'h02, 8'h00);
        check("irq_empty_set", {15'b0, irq}, 16'h0001);
        access(1'b0, ADDR_STATUS, 8'h00, 8'h03);
        access(1'b1, ADDR_IRQ_EN, 8'h00, 8'h00);
        step();
        check("irq_disabled", {15'b0, irq}, 16'h0000);

        // Switches, read-data hold and unmapped addresses.
        sw = 8'hC3;
        access(1'b0, ADDR_SW, 8'h00, 8'hC3);
        check("rdata_hold", {8'h00, io_rdata}, 16'h00C3);
        access(1'b1, 8'h10, 8'h77, 8'h00);
        access(1'b0, 8'h10, 8'h00, 8'h00);
        access(1'b0, 8'h06, 8'h00, 8'h00);
        access(1'b0, ADDR_POS, 8'h00, 8'h50);

        // Reset while a COLOR write waits on a full FIFO.
        grid_ready = 1'b0;
        access(1'b1, ADDR_POS, 8'h33, 8'h00);
        for (int i = 0; i < 4; i++) begin
            grid_q.push_back({8'h33, 8'hB0 + 8'(i)});
            access(1'b1, ADDR_COLOR, 8'hB0 + 8'(i), 8'h00);
        end
        io_we = 1'b1; io_addr = ADDR_COLOR; io_wdata = 8'hB4; io_req = 1'b1;
        step();
        step();
        rst = 1'b1;
        #1;
        check("midrst_io_ack", {15'b0, io_ack}, 16'h0000);
        check("midrst_grid_wr", {15'b0, grid_wr}, 16'h0000);
        check("midrst_grid_pos", {8'h00, grid_pos}, 16'h0000);
        check("midrst_grid_color", {8'h00, grid_color}, 16'h0000);
        check("midrst_io_rdata", {8'h00, io_rdata}, 16'h0000);
        check("midrst_irq", {15'b0, irq}, 16'h0000);
        step();
        check("midrst_no_ack", {15'b0, io_ack}, 16'h0000);
        io_req = 1'b0;
        grid_q.delete();
        step();
        rst = 1'b0;
        step();
        access(1'b0, ADDR_STATUS, 8'h00, 8'h02);
        access(1'b0, ADDR_POS, 8'h00, 8'h00);
        access(1'b0, ADDR_COLOR, 8'h00, 8'h00);
        check("post_rst_grid_wr", {15'b0, grid_wr}, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
